// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end: prefix bytes,
// frame-receiver states and the arrow-key codes used by the default key table.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // {ext, scan} codes for the arrow keys (scan-code set 2)
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_DOWN  = 9'h172;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input synchronisers, PS2C glitch filter,
// start/data/parity/stop framing and an inter-edge timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       i_ps2c,
  input  logic       i_ps2d,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            r_c_sync;
  logic [1:0]            r_d_sync;
  logic [FILTER_LEN-1:0] r_taps;
  logic                  r_filt;
  frame_state_t          r_state;
  frame_state_t          w_next;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_par_ok;
  logic [TW-1:0]         r_to_cnt;
  logic                  r_frame_err;
  logic                  r_timeout;
  logic                  w_bit;
  logic                  w_fall;
  logic                  w_byte_valid;
  logic                  w_frame_err;
  logic                  w_timeout;

  assign w_bit     = r_d_sync[1];
  assign w_fall    = r_filt & ~|r_taps;
  assign w_timeout = (r_state != IDLE) && !w_fall &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_c_sync <= '0;
      r_d_sync <= '0;
      r_taps   <= '0;
      r_filt   <= 1'b0;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2c};
      r_d_sync <= {r_d_sync[0], i_ps2d};
      r_taps   <= {r_taps[FILTER_LEN-2:0], r_c_sync[1]};
      if (&r_taps)       r_filt <= 1'b1;
      else if (~|r_taps) r_filt <= 1'b0;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    if (w_timeout) begin
      w_next = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_bit) w_next = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_next = PARITY;
        PARITY:  w_next = STOP;
        STOP: begin
          w_next = IDLE;
          if (w_bit && r_par_ok) w_byte_valid = 1'b1;
          else                   w_frame_err  = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_ok    <= 1'b0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_frame_err <= w_frame_err;
      r_timeout   <= w_timeout;
      if (w_fall || w_timeout || r_state == IDLE) r_to_cnt <= '0;
      else                                        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          // odd parity: data plus parity bit must hold an odd number of ones
          PARITY:  r_par_ok <= ^{r_shift, w_bit};
          default: ;
        endcase
      end
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_timeout    = r_timeout;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: E0/F0 prefix decoding on top of ps2_rx_frame and a
// held/press/release tracker for a configurable table of key codes.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                 NKEYS          = 4,
  parameter logic [9*NKEYS-1:0] KEY_CODES      = {KEY_DOWN, KEY_RIGHT, KEY_UP, KEY_LEFT},
  parameter int                 FILTER_LEN     = 8,
  parameter int                 TIMEOUT_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             PS2C,
  input  logic             PS2D,
  output logic [NKEYS-1:0] key_held,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             code_valid,
  output logic [8:0]       code,
  output logic             code_break,
  output logic             parity_err
);

  logic [7:0]       w_byte;
  logic             w_byte_valid;
  logic             w_frame_err;
  logic             w_timeout;
  logic             r_ext;
  logic             r_brk;
  logic             r_code_valid;
  logic [8:0]       r_code;
  logic             r_code_break;
  logic [NKEYS-1:0] r_held;
  logic [NKEYS-1:0] r_press;
  logic [NKEYS-1:0] r_release;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .clr          (clr),
    .i_ps2c       (PS2C),
    .i_ps2d       (PS2D),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_timeout    (w_timeout)
  );

  // Prefix decoder: a broken or abandoned frame also cancels pending prefixes
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_code_valid <= 1'b0;
      r_code       <= '0;
      r_code_break <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_frame_err || w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_code_valid <= 1'b1;
          r_code       <= {r_ext, w_byte};
          r_code_break <= r_brk;
          r_ext        <= 1'b0;
          r_brk        <= 1'b0;
        end
      end
    end
  end

  // Each table entry is matched independently, so duplicate codes all respond
  always_ff @(posedge clk) begin
    if (clr) begin
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= '0;
      r_release <= '0;
      if (r_code_valid) begin
        for (int i = 0; i < NKEYS; i++) begin
          if (KEY_CODES[9*i +: 9] == r_code) begin
            if (!r_code_break && !r_held[i]) begin
              r_held[i]  <= 1'b1;
              r_press[i] <= 1'b1;
            end else if (r_code_break && r_held[i]) begin
              r_held[i]    <= 1'b0;
              r_release[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign code_valid  = r_code_valid;
  assign code        = r_code;
  assign code_break  = r_code_break;
  assign parity_err  = w_frame_err;

endmodule
